// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the mini-SRC control slice: branch-step states and
// the IR[20:19] condition-field encodings.
package src_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T3   = 3'd1,
      T4   = 3'd2,
      T5   = 3'd3,
      T6   = 3'd4,
      NT   = 3'd5
   } state_t;

   localparam logic [1:0] COND_ZERO     = 2'b00;
   localparam logic [1:0] COND_NONZERO  = 2'b01;
   localparam logic [1:0] COND_POSITIVE = 2'b10;
   localparam logic [1:0] COND_NEGATIVE = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_count <= '0;
      end else if (inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch step sequencer (T3..T6) for the mini-SRC datapath, with
// optional early exit on a not-taken branch and a saturating taken counter.
module branch_seq
   import src_ctrl_pkg::*;
#(
   parameter bit SKIP_NOT_TAKEN = 1'b0,
   parameter int CNT_W          = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             con_in,
   output logic             Gra,
   output logic             Rout,
   output logic             CONin,
   output logic             PCout,
   output logic             Yin,
   output logic             Cout,
   output logic             alu_add,
   output logic             Zin,
   output logic             Zlowout,
   output logic             PCin,
   output logic             busy,
   output logic             done,
   output logic             taken,
   output logic [CNT_W-1:0] taken_cnt
);

   state_t r_state;
   state_t w_nextState;
   logic   r_taken;
   logic   w_inc;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // CON flip-flop: captures the condition only at the end of T3.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_taken <= 1'b0;
      end else if (r_state == T3) begin
         r_taken <= con_in;
      end
   end

   always_comb begin
      w_nextState = r_state;
      Gra         = 1'b0;
      Rout        = 1'b0;
      CONin       = 1'b0;
      PCout       = 1'b0;
      Yin         = 1'b0;
      Cout        = 1'b0;
      alu_add     = 1'b0;
      Zin         = 1'b0;
      Zlowout     = 1'b0;
      PCin        = 1'b0;
      done        = 1'b0;
      busy        = (r_state != IDLE);
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = T3;
            end
         end
         T3: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            CONin = 1'b1;
            if (SKIP_NOT_TAKEN && !con_in) begin
               w_nextState = NT;
            end else begin
               w_nextState = T4;
            end
         end
         T4: begin
            PCout       = 1'b1;
            Yin         = 1'b1;
            w_nextState = T5;
         end
         T5: begin
            Cout        = 1'b1;
            alu_add     = 1'b1;
            Zin         = 1'b1;
            w_nextState = T6;
         end
         T6: begin
            Zlowout     = 1'b1;
            PCin        = r_taken;
            done        = 1'b1;
            w_nextState = IDLE;
         end
         NT: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign w_inc = (r_state == T6) && r_taken;
   assign taken = r_taken;

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_takenCnt (
      .clock(clock),
      .clear(clear),
      .inc  (w_inc),
      .count(taken_cnt)
   );

endmodule

// File: doc/branch_seq.md
# branch_seq

Branch-step sequencer for the mini-SRC datapath. When the main control unit hands over a conditional branch (`br`) instruction, this block drives the datapath strobes for steps T3–T6 in order:

- T3 loads the branch condition flag from the condition logic.
- T4–T5 compute PC + C.
- T6 conditionally loads PC.

It sits between the main control unit and the datapath. It returns control with a `done` pulse and keeps a saturating count of taken branches.

## Interface
Parameters:
- `SKIP_NOT_TAKEN`, default 0: when 1, a not-taken branch skips T4–T6 and finishes early.
- `CNT_W`, default 16: width of the taken-branch counter.

Ports:
- `clock`, input, 1: single clock; all state changes on its rising edge.
- `clear`, input, 1: reset, asynchronous and active-high.
- `start`, input, 1: handoff pulse from the main control unit; sampled only in IDLE.
- `con_in`, input, 1: combinational branch-condition result (zero / nonzero / positive / negative per IR[20:19] applied to the bus); valid during T3.
- `Gra`, `Rout`, `CONin`, output, 1 each: T3 strobes.
- `PCout`, `Yin`, output, 1 each: T4 strobes.
- `Cout`, `alu_add`, `Zin`, output, 1 each: T5 strobes.
- `Zlowout`, `PCin`, output, 1 each: T6 strobes; `PCin` is gated by the latched condition.
- `busy`, output, 1: high in every non-IDLE state.
- `done`, output, 1: one-cycle pulse in the final step of the sequence.
- `taken`, output, 1: latched condition flag (CON flip-flop).
- `taken_cnt`, output, `CNT_W`: saturating count of taken branches.

## Operation
- States are IDLE, T3, T4, T5, T6 and NT. NT exists only when `SKIP_NOT_TAKEN` = 1.
- IDLE → T3 when `start` = 1. Otherwise stay in IDLE.
- T3 drives `Gra`, `Rout` and `CONin`. At the end of T3, `taken` <= `con_in`.
  - Next state is NT if `SKIP_NOT_TAKEN` and !`con_in`.
  - Otherwise next state is T4.
- T4 drives `PCout` and `Yin`. T4 → T5.
- T5 drives `Cout`, `alu_add` and `Zin`. T5 → T6.
- T6 drives `Zlowout`, `PCin` = `taken`, and `done` = 1. T6 → IDLE.
  - If `taken` = 1, `taken_cnt` increments at the end of T6.
- NT drives `done` = 1 and no datapath strobes. NT → IDLE.
- All strobes are Moore outputs decoded from the state register. At most one step's strobe group is active in any cycle.
- `start` in any non-IDLE state is ignored; it is neither queued nor counted.
- `taken` holds its value until the next T3.
- `taken_cnt` saturates at 2^`CNT_W`−1 and does not wrap.

## Timing
- Reset values while `clear` = 1: state IDLE, every strobe 0, `busy` 0, `done` 0, `taken` 0, `taken_cnt` 0. Reset takes effect immediately and is asynchronous.
- `clear` asserted mid-sequence aborts the sequence:
  - no `PCin` and no `done` are produced;
  - `taken_cnt` keeps only the increments already committed, and is then zeroed by the reset itself.
- Latency from the `start`-sampled edge:
  - T3 is the next cycle.
  - Full path: `done` in the 4th cycle (T6).
  - Skip path: `done` in the 2nd cycle (NT).
- `busy` goes high the cycle after `start` is sampled and drops the cycle after `done`.
- Back-to-back: `start` asserted during the `done` cycle is ignored. The earliest accepted `start` is in the first IDLE cycle, so the minimum gap between sequences is one IDLE cycle.
- `con_in` is sampled only at the T3→next edge. Changes in any other cycle have no effect.

## Structure
- Shared package `src_ctrl_pkg`:
  - state enum (IDLE, T3, T4, T5, T6, NT);
  - the IR condition-field encodings (00 zero, 01 nonzero, 10 positive, 11 negative), for use by the bench model.
- Sub-module `sat_counter` (parameter `CNT_W`, ports `clock`/`clear`/`inc`/`count`) holds the taken counter.
- The FSM and output decode live in `branch_seq` itself.

## Test plan
- `SKIP_NOT_TAKEN` = 0, `start` pulse, `con_in` = 1 in T3:
  - T3, T4, T5, T6 strobes appear in the 4 following cycles;
  - `PCin` = 1 and `done` = 1 in T6;
  - `taken` = 1 and `taken_cnt` 0→1.
- `SKIP_NOT_TAKEN` = 0, `con_in` = 0:
  - full 4-step sequence runs;
  - `PCin` = 0 in T6, `done` = 1;
  - `taken` = 0 and `taken_cnt` unchanged.
- `SKIP_NOT_TAKEN` = 1, `con_in` = 0:
  - T3 is followed by NT with `done` = 1 and no strobes;
  - `busy` is high for exactly 2 cycles.
- `start` held high for 10 cycles with `con_in` = 1:
  - exactly two sequences run, separated by one IDLE cycle;
  - `taken_cnt` = 2.
- `clear` pulsed during T5:
  - all outputs go to 0 immediately;
  - no `PCin` and no `done`;
  - the next `start` runs normally from T3.
- `CNT_W` = 2, five taken branches:
  - `taken_cnt` reads 1, 2, 3, 3, 3.
